// File: rtl/cpu1_sequencer.sv
// Multi-cycle control sequencer for the cpu1 accumulator datapath.
// Steps FETCH/EXEC/WAIT/WB, with run/single-step/halt control and a retire counter.
module cpu1_sequencer #(
    parameter int unsigned WORD_W   = 8,
    parameter int unsigned OP_W     = 3,
    parameter int unsigned DMEM_LAT = 1
) (
    input  logic              clock,
    input  logic              n_reset,
    input  logic [OP_W-1:0]   op,
    input  logic              z_flag,
    input  logic              run,
    input  logic              step,
    output logic              load_IR,
    output logic              INC_PC,
    output logic              load_PC,
    output logic              load_REG,
    output logic              ALU_REG,
    output logic              ALU_add,
    output logic              ALU_sub,
    output logic              IMM,
    output logic              WE,
    output logic              halted,
    output logic              busy,
    output logic [WORD_W-1:0] retired
);

    localparam logic [OP_W-1:0] OpNop = OP_W'(0);
    localparam logic [OP_W-1:0] OpLda = OP_W'(1);
    localparam logic [OP_W-1:0] OpSta = OP_W'(2);
    localparam logic [OP_W-1:0] OpAdd = OP_W'(3);
    localparam logic [OP_W-1:0] OpSub = OP_W'(4);
    localparam logic [OP_W-1:0] OpLdi = OP_W'(5);
    localparam logic [OP_W-1:0] OpBne = OP_W'(6);
    localparam logic [OP_W-1:0] OpHlt = OP_W'(7);

    // WAIT spans DMEM_LAT-1 cycles; the counter holds the remaining extra cycles.
    localparam logic [1:0] WaitInit = (DMEM_LAT >= 2) ? 2'(DMEM_LAT - 2) : 2'd0;

    typedef enum logic [2:0] {
        StIdle,
        StFetch,
        StExec,
        StWait,
        StWb,
        StHalt
    } state_e;

    state_e            state_q;
    logic              step_flag_q;
    logic [1:0]        wait_cnt_q;
    logic [WORD_W-1:0] retired_q;

    logic is_read;
    logic done;

    assign is_read = (op == OpLda) || (op == OpAdd) || (op == OpSub);

    // Strobes depend on state and, in EXEC/WB, on the opcode currently held in ir.
    always_comb begin
        load_IR  = 1'b0;
        INC_PC   = 1'b0;
        load_PC  = 1'b0;
        load_REG = 1'b0;
        ALU_REG  = 1'b0;
        ALU_add  = 1'b0;
        ALU_sub  = 1'b0;
        IMM      = 1'b0;
        WE       = 1'b0;
        done     = 1'b0;
        case (state_q)
            StFetch: load_IR = 1'b1;
            StExec: begin
                case (op)
                    OpNop: begin
                        INC_PC = 1'b1;
                        done   = 1'b1;
                    end
                    OpSta: begin
                        WE     = 1'b1;
                        INC_PC = 1'b1;
                        done   = 1'b1;
                    end
                    OpLdi: begin
                        IMM      = 1'b1;
                        ALU_REG  = 1'b1;
                        load_REG = 1'b1;
                        INC_PC   = 1'b1;
                        done     = 1'b1;
                    end
                    OpBne: begin
                        load_PC = ~z_flag;
                        INC_PC  = z_flag;
                        done    = 1'b1;
                    end
                    OpLda, OpAdd, OpSub: begin
                        if (DMEM_LAT == 0) begin
                            ALU_REG  = (op == OpLda);
                            ALU_add  = (op == OpAdd);
                            ALU_sub  = (op == OpSub);
                            load_REG = 1'b1;
                            INC_PC   = 1'b1;
                            done     = 1'b1;
                        end
                    end
                    default: ;
                endcase
            end
            StWb: begin
                ALU_REG  = (op == OpLda);
                ALU_add  = (op == OpAdd);
                ALU_sub  = (op == OpSub);
                load_REG = 1'b1;
                INC_PC   = 1'b1;
                done     = 1'b1;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clock or negedge n_reset) begin
        if (!n_reset) begin
            state_q     <= StIdle;
            step_flag_q <= 1'b0;
            wait_cnt_q  <= 2'd0;
            retired_q   <= '0;
        end else begin
            case (state_q)
                StIdle: begin
                    if (run) begin
                        state_q     <= StFetch;
                        step_flag_q <= 1'b0;
                    end else if (step) begin
                        state_q     <= StFetch;
                        step_flag_q <= 1'b1;
                    end
                end
                StFetch: state_q <= StExec;
                StExec: begin
                    if (op == OpHlt) begin
                        state_q     <= StHalt;
                        retired_q   <= retired_q + WORD_W'(1);
                        step_flag_q <= 1'b0;
                    end else if (is_read && (DMEM_LAT != 0)) begin
                        state_q    <= (DMEM_LAT == 1) ? StWb : StWait;
                        wait_cnt_q <= WaitInit;
                    end
                end
                StWait: begin
                    if (wait_cnt_q == 2'd0) begin
                        state_q <= StWb;
                    end else begin
                        wait_cnt_q <= wait_cnt_q - 2'd1;
                    end
                end
                StHalt: state_q <= StHalt;
                default: ;
            endcase
            if (done) begin
                retired_q   <= retired_q + WORD_W'(1);
                step_flag_q <= 1'b0;
                state_q     <= (run && !step_flag_q) ? StFetch : StIdle;
            end
        end
    end

    assign halted  = (state_q == StHalt);
    assign busy    = (state_q == StFetch) || (state_q == StExec) ||
                     (state_q == StWait) || (state_q == StWb);
    assign retired = retired_q;

endmodule
